// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the hazard unit.
// Holds the FSM state encoding and default register address width.
package hazard_ctrl_pkg;

  localparam int HZ_REG_ADDR_WIDTH = 5;

  typedef enum logic {
    HZ_STATE_RUN   = 1'b0,
    HZ_STATE_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_fl;
    logic id_ex_fl;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam hz_ctrl_t HZ_CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam hz_ctrl_t HZ_CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1};
  localparam hz_ctrl_t HZ_CTRL_RESET = '{1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_dep_cmp.sv
// hazard_dep_cmp: one source/destination dependency match.
// Register 0 is hardwired and never creates a dependency.
module hazard_dep_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] src,
  input  logic         src_used,
  input  logic [W-1:0] dst,
  output logic         match
);

  // Match only on a used source against a real (nonzero) destination
  always_comb begin
    match = src_used && (dst != '0) && (src == dst);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for PC, IF/ID and ID/EX latches.
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
import hazard_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      id_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0] ex_dst,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dst,
  input  logic                      mem_mem_read,
  input  logic                      ex_mispredict,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]      perf_stall_cycles,
  output logic [CNT_WIDTH-1:0]      perf_flush_events,
  output logic [CNT_WIDTH-1:0]      perf_load_use,
`endif
  output logic                      pc_write_en,
  output logic                      if_id_write_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      stall_active
);

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic match_ex, match_mem;
  logic load_use, need1, need2;

  hz_state_e state_q, state_d;
  logic [1:0] stall_cnt_q, stall_cnt_d;
  hz_ctrl_t   ctrl;
  logic       do_stall, do_flush;

  hazard_dep_cmp #(.W(REG_ADDR_WIDTH)) u_rs_ex (
    .src      (id_rs),
    .src_used (id_uses_rs),
    .dst      (ex_dst),
    .match    (rs_ex)
  );

  hazard_dep_cmp #(.W(REG_ADDR_WIDTH)) u_rt_ex (
    .src      (id_rt),
    .src_used (id_uses_rt),
    .dst      (ex_dst),
    .match    (rt_ex)
  );

  hazard_dep_cmp #(.W(REG_ADDR_WIDTH)) u_rs_mem (
    .src      (id_rs),
    .src_used (id_uses_rs),
    .dst      (mem_dst),
    .match    (rs_mem)
  );

  hazard_dep_cmp #(.W(REG_ADDR_WIDTH)) u_rt_mem (
    .src      (id_rt),
    .src_used (id_uses_rt),
    .dst      (mem_dst),
    .match    (rt_mem)
  );

  // Hazard classes; need2 is a subset of the load-use term
  always_comb begin
    match_ex  = rs_ex | rt_ex;
    match_mem = rs_mem | rt_mem;
    load_use  = ex_mem_read & match_ex;
    need2     = id_is_branch & ex_mem_read & match_ex;
    need1     = load_use
              | (id_is_branch & ex_reg_write
                 & ~ex_mem_read & match_ex)
              | (id_is_branch & mem_mem_read & match_mem);
  end

  // Next state, stall counter and latch controls
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    ctrl        = HZ_CTRL_RUN;
    do_stall    = 1'b0;
    do_flush    = 1'b0;
    if (reset) begin
      ctrl        = HZ_CTRL_RESET;
      state_d     = HZ_STATE_RUN;
      stall_cnt_d = 2'd0;
    end else begin
      unique case (state_q)
        HZ_STATE_RUN: begin
          if (ex_mispredict) begin
            ctrl     = HZ_CTRL_FLUSH;
            do_flush = 1'b1;
          end else if (need2) begin
            ctrl        = HZ_CTRL_STALL;
            do_stall    = 1'b1;
            state_d     = HZ_STATE_STALL;
            stall_cnt_d = 2'd1;
          end else if (need1) begin
            ctrl     = HZ_CTRL_STALL;
            do_stall = 1'b1;
          end
        end
        HZ_STATE_STALL: begin
          if (ex_mispredict) begin
            ctrl        = HZ_CTRL_FLUSH;
            do_flush    = 1'b1;
            state_d     = HZ_STATE_RUN;
            stall_cnt_d = 2'd0;
          end else begin
            ctrl        = HZ_CTRL_STALL;
            do_stall    = 1'b1;
            stall_cnt_d = stall_cnt_q - 2'd1;
            if (stall_cnt_d == 2'd0) begin
              state_d = HZ_STATE_RUN;
            end
          end
        end
        default: begin
          state_d     = HZ_STATE_RUN;
          stall_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HZ_STATE_RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Drive the latch control ports
  always_comb begin
    pc_write_en    = ctrl.pc_we;
    if_id_write_en = ctrl.if_id_we;
    if_id_flush    = ctrl.if_id_fl;
    id_ex_flush    = ctrl.id_ex_fl;
    stall_active   = ~reset & (state_q == HZ_STATE_STALL);
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_WIDTH-1:0] flush_ev_q, flush_ev_d;
  logic [CNT_WIDTH-1:0] lu_q, lu_d;
  logic                 lu_hit;

  // Saturating event counters
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_ev_d  = flush_ev_q;
    lu_d        = lu_q;
    lu_hit      = ~reset & (state_q == HZ_STATE_RUN)
                & ~ex_mispredict & load_use;
    if (do_stall && stall_cyc_q != '1) begin
      stall_cyc_d = stall_cyc_q + CNT_ONE;
    end
    if (do_flush && flush_ev_q != '1) begin
      flush_ev_d = flush_ev_q + CNT_ONE;
    end
    if (lu_hit && lu_q != '1) begin
      lu_d = lu_q + CNT_ONE;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cyc_q <= '0;
      flush_ev_q  <= '0;
      lu_q        <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_ev_q  <= flush_ev_d;
      lu_q        <= lu_d;
    end
  end

  // Counter outputs
  always_comb begin
    perf_stall_cycles = stall_cyc_q;
    perf_flush_events = flush_ev_q;
    perf_load_use     = lu_q;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a scoreboard queue.
// Output vector order: pc_we, if_id_we, if_id_fl, id_ex_fl, stall.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_uses_rs, id_uses_rt, id_is_branch;
  logic       ex_reg_write, ex_mem_read, mem_mem_read;
  logic       ex_mispredict;
  logic       pc_write_en, if_id_write_en;
  logic       if_id_flush, id_ex_flush, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_events, perf_load_use;
`endif

  localparam logic [4:0] RUNO = 5'b11000;
  localparam logic [4:0] STL  = 5'b00010;
  localparam logic [4:0] STLS = 5'b00011;
  localparam logic [4:0] FLS  = 5'b11110;
  localparam logic [4:0] FLSS = 5'b11111;
  localparam logic [4:0] RSTO = 5'b00110;

  typedef struct {
    logic [4:0] o;
    bit         pz;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_is_branch   (id_is_branch),
    .ex_dst         (ex_dst),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .mem_dst        (mem_dst),
    .mem_mem_read   (mem_mem_read),
    .ex_mispredict  (ex_mispredict),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events),
    .perf_load_use     (perf_load_use),
`endif
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .stall_active   (stall_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(
    input string      nm,
    input logic       rst,
    input logic [4:0] rs,
    input logic       urs,
    input logic [4:0] rt,
    input logic       urt,
    input logic       br,
    input logic [4:0] exd,
    input logic       exrw,
    input logic       exmr,
    input logic [4:0] memd,
    input logic       memmr,
    input logic       misp,
    input logic [4:0] exp_o,
    input bit         pz = 1'b0
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    id_rs         = rs;
    id_uses_rs    = urs;
    id_rt         = rt;
    id_uses_rt    = urt;
    id_is_branch  = br;
    ex_dst        = exd;
    ex_reg_write  = exrw;
    ex_mem_read   = exmr;
    mem_dst       = memd;
    mem_mem_read  = memmr;
    ex_mispredict = misp;
    e.o  = exp_o;
    e.pz = pz;
    e.nm = nm;
    sb_q.push_back(e);
  endtask

  initial begin : mon
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {pc_write_en, if_id_write_en, if_id_flush,
               id_ex_flush, stall_active};
        checks++;
        if (got !== e.o) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.nm, got, e.o);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (e.pz) begin
          checks++;
          if ({perf_stall_cycles, perf_flush_events,
               perf_load_use} !== '0) begin
            errors++;
            $display("FAIL %s_perf: got %0d/%0d/%0d expected 0/0/0",
                     e.nm, perf_stall_cycles, perf_flush_events,
                     perf_load_use);
          end
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    {id_rs, id_rt, ex_dst, mem_dst} = '0;
    {id_uses_rs, id_uses_rt, id_is_branch} = '0;
    {ex_reg_write, ex_mem_read, mem_mem_read} = '0;
    ex_mispredict = 1'b0;

    step("rst0",       1, 0,0, 0,0, 0, 0,0,0, 0,0, 0, RSTO);
    step("rst1",       1, 0,0, 0,0, 0, 0,0,0, 0,0, 0, RSTO);
    step("idle",       0, 1,1, 4,1, 0, 9,1,0, 10,1, 0, RUNO);
    step("lu_stall",   0, 2,1, 0,0, 0, 2,1,1, 0,0, 0, STL);
    step("lu_resume",  0, 2,1, 0,0, 0, 0,0,0, 2,1, 0, RUNO);
    step("lu_rt",      0, 0,0, 2,1, 0, 2,1,1, 0,0, 0, STL);
    step("lu_rt_run",  0, 0,0, 2,1, 0, 0,0,0, 2,1, 0, RUNO);
    step("br_ld_s0",   0, 0,0, 3,1, 1, 3,1,1, 0,0, 0, STL);
    step("br_ld_s1",   0, 0,0, 3,1, 1, 0,0,0, 3,1, 0, STLS);
    step("br_ld_run",  0, 0,0, 3,1, 1, 0,0,0, 0,0, 0, RUNO);
    step("x0",         0, 0,1, 0,0, 0, 0,1,1, 0,0, 0, RUNO);
    step("x0_br",      0, 0,1, 0,1, 1, 0,1,1, 0,1, 0, RUNO);
    step("unused_src", 0, 7,0, 0,0, 0, 7,1,1, 0,0, 0, RUNO);
    step("misp_lu",    0, 2,1, 0,0, 0, 2,1,1, 0,0, 1, FLS);
    step("misp_after", 0, 2,1, 0,0, 0, 0,0,0, 0,0, 0, RUNO);
    step("abort_s0",   0, 0,0, 3,1, 1, 3,1,1, 0,0, 0, STL);
    step("abort_fl",   0, 0,0, 3,1, 1, 0,0,0, 3,1, 1, FLSS);
    step("abort_run",  0, 0,0, 0,0, 0, 0,0,0, 0,0, 0, RUNO);
    step("alu_br",     0, 5,1, 0,0, 1, 5,1,0, 0,0, 0, STL);
    step("alu_br_run", 0, 5,1, 0,0, 1, 0,0,0, 5,0, 0, RUNO);
    step("mem_ld_br",  0, 6,1, 0,0, 1, 0,0,0, 6,1, 0, STL);
    step("mem_ld_run", 0, 6,1, 0,0, 1, 0,0,0, 0,0, 0, RUNO);
    step("alu_nobr",   0, 5,1, 0,0, 0, 5,1,0, 0,0, 0, RUNO);
    step("ldsoon_nobr",0, 6,1, 0,0, 0, 0,0,0, 6,1, 0, RUNO);
    step("rst_s0",     0, 0,0, 3,1, 1, 3,1,1, 0,0, 0, STL);
    step("rst_mid",    1, 0,0, 3,1, 1, 0,0,0, 3,1, 0, RSTO);
    step("post_rst",   0, 0,0, 0,0, 0, 0,0,0, 0,0, 0, RUNO, 1'b1);
    step("post_rst2",  0, 2,1, 0,0, 0, 2,1,1, 0,0, 0, STL);

    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
